maxnet_engine: RTL and testbench
================================

MAXNET_ENGINE -- requirements
Module: maxnet_engine

Interface
REQ-001 Parameter N, default 4: number of competing channels, N >= 2.
REQ-002 Parameter W, default 32: unsigned activation width.
REQ-003 Parameter FRAC, default 16: fractional bits of epsilon (unsigned Q(W-FRAC).FRAC).
REQ-004 Parameter MAX_ITER, default 64: iteration limit, >= 1.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request a new competition; sampled only in IDLE.
REQ-008 a_init  in  N*W  initial activations; channel i at bits [i*W +: W].
REQ-009 epsilon  in  W  inhibition weight, captured with a_init.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 winner  out  clog2(N)  index of the surviving channel.
REQ-013 winner_valid  out  1  exactly one nonzero activation at completion.
REQ-014 out  out  W  final activation of the winner, 0 when winner_valid=0.
REQ-015 timeout  out  1  completion caused by MAX_ITER.
REQ-016 iter_count  out  clog2(MAX_ITER+1)  iterations executed.
REQ-017 act_out  out  N*W  current activation registers.

Function
REQ-018 FSM states are IDLE, CHECK, SUM, UPDATE and DONE.
REQ-019 In IDLE with start=1, the block registers a_init and epsilon, clears iter_count, timeout, winner_valid, winner and out, and moves to CHECK.
REQ-020 CHECK (1 cycle) counts nonzero activations: count<=1 -> DONE; else iter_count==MAX_ITER -> DONE with timeout=1; else -> SUM.
REQ-021 SUM (N cycles, index 0..N-1) accumulates S = sum of all a_j into a W+clog2(N)-bit register, with no overflow.
REQ-022 UPDATE (N cycles, index 0..N-1) computes, per cycle, a_i <= max(0, a_i - ((epsilon*(S-a_i)) >> FRAC)) at full product width, truncating toward zero; S is frozen, so in-place update order does not affect results.
REQ-023 On leaving UPDATE, iter_count increments and the FSM returns to CHECK.
REQ-024 One iteration takes 2N+1 cycles; done rises 2+I*(2N+1) rising edges after the start-sampling edge, where I is the final iter_count.
REQ-025 On entry to DONE, if exactly one activation is nonzero: winner = its index, out = its value, winner_valid=1; otherwise winner=0, out=0, winner_valid=0.
REQ-026 DONE lasts one cycle with done=1, then returns to IDLE; winner, winner_valid, out, timeout, iter_count and act_out hold until the next accepted start.
REQ-027 start is ignored while busy=1, and may be accepted in the IDLE cycle immediately after DONE.
REQ-028 epsilon=0 leaves activations unchanged, so the run ends by timeout unless the initial count is <=1.
REQ-029 Ties are never broken arbitrarily: equal survivors either resolve through the arithmetic or end by timeout with winner_valid=0.

Reset
REQ-030 rst=0 asynchronously forces IDLE and zeroes all outputs, activation, sum, index and iteration registers, including mid-run.
REQ-031 After rst deasserts, the first start is accepted on the first rising edge at which start=1.

Verification
REQ-032 N=4, FRAC=16, eps=0x4000, a=(10,20,30,40) -> after iter 1 act=(0,0,13,25); final act=(0,0,0,21), winner=3, out=21, iter_count=4, timeout=0; done 38 edges after start.
REQ-033 eps=0x4000, a=(5,5,5,5), MAX_ITER=8 -> act after iter1=(2,2,2,2), then stalls at (1,1,1,1); timeout=1, winner_valid=0, out=0, iter_count=8.
REQ-034 a=(0,0,77,0) -> done 2 edges after start, iter_count=0, winner=2, out=77, winner_valid=1.
REQ-035 a=(0,0,0,0) -> done after 2 edges, winner_valid=0, out=0, timeout=0.
REQ-036 Pulse start again during SUM of the REQ-032 run -> ignored, results identical; then assert rst=0 mid-UPDATE -> busy, done and all outputs are 0 immediately; a new start afterwards reproduces REQ-032 exactly.

Source files
------------

// File: rtl/maxnet_engine.sv
// MAXNET winner-take-all engine: iterated lateral inhibition over N channels.
// Each iteration sums all activations (N cycles), then updates them one per cycle (N cycles).
module maxnet_engine #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int FRAC     = 16,
  parameter int MAX_ITER = 64,
  localparam int LG      = $clog2(N),
  localparam int IW      = $clog2(MAX_ITER + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*W-1:0] a_init,
  input  logic [W-1:0]   epsilon,
  output logic           busy,
  output logic           done,
  output logic [LG-1:0]  winner,
  output logic           winner_valid,
  output logic [W-1:0]   out,
  output logic           timeout,
  output logic [IW-1:0]  iter_count,
  output logic [N*W-1:0] act_out,
  output logic [2:0]     state_dbg
);

  localparam int SW = W + LG;
  localparam int PW = W + SW;

  typedef enum logic [2:0] {IDLE, CHECK, SUM, UPDATE, DONE} state_t;

  // Handshake: start is sampled only while busy=0 (IDLE); done is a one-cycle
  // pulse and the result outputs stay stable until the next accepted start.
  state_t        state;
  logic [W-1:0]  act [N];
  logic [W-1:0]  eps_r;
  logic [SW-1:0] sum;
  logic [LG-1:0] idx;

  logic [LG:0]   nz_count;
  logic [LG-1:0] nz_last;
  logic [W-1:0]  cur;
  logic [SW-1:0] diff;
  logic [PW-1:0] prod;
  logic [PW-1:0] inhib;
  logic [W-1:0]  upd;

  assign state_dbg = state;

  always_comb begin
    act_out = '0;
    for (int i = 0; i < N; i++) act_out[i*W +: W] = act[i];
  end

  always_comb begin
    nz_count = '0;
    nz_last  = '0;
    for (int i = 0; i < N; i++) begin
      if (act[i] != '0) begin
        nz_count = nz_count + (LG+1)'(1);
        nz_last  = LG'(i);
      end
    end
  end

  // S is frozen during UPDATE, so in-place writes never disturb later channels.
  always_comb begin
    cur   = act[idx];
    diff  = sum - SW'(cur);
    prod  = PW'(eps_r) * PW'(diff);
    inhib = prod >> FRAC;
    if (inhib >= PW'(cur)) upd = '0;
    else                   upd = cur - W'(inhib);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      for (int i = 0; i < N; i++) act[i] <= '0;
      eps_r        <= '0;
      sum          <= '0;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
      out          <= '0;
      timeout      <= 1'b0;
      iter_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < N; i++) act[i] <= a_init[i*W +: W];
            eps_r        <= epsilon;
            iter_count   <= '0;
            timeout      <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= '0;
            out          <= '0;
            busy         <= 1'b1;
            state        <= CHECK;
          end
        end
        CHECK: begin
          if (nz_count <= (LG+1)'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            if (nz_count == (LG+1)'(1)) begin
              winner       <= nz_last;
              out          <= act[nz_last];
              winner_valid <= 1'b1;
            end
          end else if (iter_count == IW'(MAX_ITER)) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            sum   <= '0;
            idx   <= '0;
            state <= SUM;
          end
        end
        SUM: begin
          sum <= sum + SW'(act[idx]);
          if (idx == LG'(N - 1)) begin
            idx   <= '0;
            state <= UPDATE;
          end else begin
            idx <= idx + LG'(1);
          end
        end
        UPDATE: begin
          act[idx] <= upd;
          if (idx == LG'(N - 1)) begin
            idx        <= '0;
            iter_count <= iter_count + IW'(1);
            state      <= CHECK;
          end else begin
            idx <= idx + LG'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_engine.sv
// Self-checking bench for maxnet_engine: directed scenarios plus random
// back-to-back competitions checked against a scoreboard of expected results.
module tb_maxnet_engine;

  typedef struct packed {
    logic [1:0]   winner;
    logic         valid;
    logic [31:0]  out;
    logic         timeout;
    logic [6:0]   iter;
    logic [127:0] act;
    logic [127:0] act1;
    logic [15:0]  lat;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         start8 = 1'b0;
  logic [127:0] a_init = '0;
  logic [31:0]  epsilon = '0;
  logic         use8 = 1'b0;

  logic         busy1, done1, valid1, to1, busy8, done8, valid8, to8;
  logic [1:0]   winner1, winner8;
  logic [31:0]  out1, out8;
  logic [6:0]   iter1;
  logic [3:0]   iter8;
  logic [127:0] act1_o, act8_o;
  logic [2:0]   st1, st8;

  logic         o_done, o_valid, o_to;
  logic [1:0]   o_winner;
  logic [31:0]  o_out;
  logic [6:0]   o_iter;
  logic [127:0] o_act;

  res_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  maxnet_engine #(.N(4), .W(32), .FRAC(16), .MAX_ITER(64)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a_init(a_init), .epsilon(epsilon),
    .busy(busy1), .done(done1), .winner(winner1), .winner_valid(valid1),
    .out(out1), .timeout(to1), .iter_count(iter1), .act_out(act1_o), .state_dbg(st1)
  );

  maxnet_engine #(.N(4), .W(32), .FRAC(16), .MAX_ITER(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_init(a_init), .epsilon(epsilon),
    .busy(busy8), .done(done8), .winner(winner8), .winner_valid(valid8),
    .out(out8), .timeout(to8), .iter_count(iter8), .act_out(act8_o), .state_dbg(st8)
  );

  assign o_done   = use8 ? done8   : done1;
  assign o_valid  = use8 ? valid8  : valid1;
  assign o_to     = use8 ? to8     : to1;
  assign o_winner = use8 ? winner8 : winner1;
  assign o_out    = use8 ? out8    : out1;
  assign o_iter   = use8 ? {3'b000, iter8} : iter1;
  assign o_act    = use8 ? act8_o  : act1_o;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic res_t ref_model(input logic [127:0] a_in, input logic [31:0] eps,
                                     input int max_iter);
    res_t        e;
    logic [31:0] a [4];
    logic [33:0] s;
    logic [65:0] p;
    int          it;
    int          cnt;
    int          last;
    bit          fin;
    e = '0;
    for (int i = 0; i < 4; i++) a[i] = a_in[i*32 +: 32];
    it = 0;
    fin = 0;
    cnt = 0;
    last = 0;
    for (int k = 0; k <= max_iter + 1 && !fin; k++) begin
      cnt = 0;
      for (int i = 0; i < 4; i++) if (a[i] != 0) begin cnt++; last = i; end
      if (cnt <= 1) fin = 1;
      else if (it == max_iter) begin e.timeout = 1'b1; fin = 1; end
      else begin
        s = '0;
        for (int i = 0; i < 4; i++) s = s + 34'(a[i]);
        for (int i = 0; i < 4; i++) begin
          p = (66'(eps) * 66'(s - 34'(a[i]))) >> 16;
          a[i] = (p >= 66'(a[i])) ? 32'd0 : a[i] - 32'(p);
        end
        it++;
        if (it == 1) for (int i = 0; i < 4; i++) e.act1[i*32 +: 32] = a[i];
      end
    end
    for (int i = 0; i < 4; i++) e.act[i*32 +: 32] = a[i];
    if (cnt == 1) begin
      e.valid  = 1'b1;
      e.winner = 2'(last);
      e.out    = a[last];
    end
    e.iter = 7'(it);
    e.lat  = 16'(2 + it * 9);
    return e;
  endfunction

  // ---------------- driver ----------------
  // lat = edges from the start-sampling edge to the edge that samples done high.
  task automatic run_dut(input logic [127:0] a, input logic [31:0] eps, input bit on8,
                         input int poke_at, input int abort_at, output res_t r, output bit ok);
    bit fin;
    bit got1;
    fin = 0;
    got1 = 0;
    ok = 0;
    r = '0;
    use8 = on8;
    @(negedge clk);
    a_init = a;
    epsilon = eps;
    if (on8) start8 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start8 = 1'b0;
    for (int k = 0; k < 2000 && !fin; k++) begin
      @(negedge clk);
      if (k == poke_at) begin
        start = 1'b1;
        a_init = ~a;
      end else if (poke_at >= 0 && k == poke_at + 1) begin
        start = 1'b0;
        a_init = a;
      end
      if (!got1 && o_iter == 7'd1) begin
        r.act1 = o_act;
        got1 = 1;
      end
      if (k == abort_at) begin
        #2 rst = 1'b0;
        fin = 1;
      end else if (o_done) begin
        r.lat     = 16'(k + 1);
        r.winner  = o_winner;
        r.valid   = o_valid;
        r.out     = o_out;
        r.timeout = o_to;
        r.iter    = o_iter;
        r.act     = o_act;
        ok = 1;
        fin = 1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0b exp 0", busy1); end
    vectors++; if (done1 !== 1'b0) begin miscompares++; $display("FAIL rst_done got %0b exp 0", done1); end
    vectors++; if ({winner1, valid1, out1, to1, iter1} !== '0) begin miscompares++; $display("FAIL rst_result got %h exp 0", {winner1, valid1, out1, to1, iter1}); end
    vectors++; if (act1_o !== '0) begin miscompares++; $display("FAIL rst_act got %h exp 0", act1_o); end
    vectors++; if ({busy8, done8, winner8, valid8, out8, to8, iter8, act8_o} !== '0) begin miscompares++; $display("FAIL rst_dut8 got %h exp 0", {busy8, done8, winner8, valid8, out8, to8, iter8, act8_o}); end
    rst = 1'b1;
  endtask

  task automatic test_example(input string tag, input int poke_at);
    res_t r, e;
    bit   ok;
    exp_q.push_back('{winner: 2'd3, valid: 1'b1, out: 32'd21, timeout: 1'b0, iter: 7'd4,
                      act: {32'd21, 32'd0, 32'd0, 32'd0}, act1: {32'd25, 32'd13, 32'd0, 32'd0},
                      lat: 16'd38});
    run_dut({32'd40, 32'd30, 32'd20, 32'd10}, 32'h4000, 1'b0, poke_at, -1, r, ok);
    e = exp_q.pop_front();
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL %s_done_seen got %0b exp 1", tag, ok); end
    vectors++; if (r.lat !== e.lat) begin miscompares++; $display("FAIL %s_latency got %0d exp %0d", tag, r.lat, e.lat); end
    vectors++; if (r.act1 !== e.act1) begin miscompares++; $display("FAIL %s_act_iter1 got %h exp %h", tag, r.act1, e.act1); end
    vectors++; if (r.winner !== e.winner || r.valid !== e.valid) begin miscompares++; $display("FAIL %s_winner got %0d/%0b exp %0d/%0b", tag, r.winner, r.valid, e.winner, e.valid); end
    vectors++; if (r.out !== e.out) begin miscompares++; $display("FAIL %s_out got %0d exp %0d", tag, r.out, e.out); end
    vectors++; if (r.iter !== e.iter || r.timeout !== e.timeout) begin miscompares++; $display("FAIL %s_iter got %0d/%0b exp %0d/%0b", tag, r.iter, r.timeout, e.iter, e.timeout); end
    vectors++; if (r.act !== e.act) begin miscompares++; $display("FAIL %s_act_final got %h exp %h", tag, r.act, e.act); end
  endtask

  task automatic test_stall();
    res_t r, e;
    bit   ok;
    exp_q.push_back('{winner: 2'd0, valid: 1'b0, out: 32'd0, timeout: 1'b1, iter: 7'd8,
                      act: {4{32'd1}}, act1: {4{32'd2}}, lat: 16'd74});
    run_dut({4{32'd5}}, 32'h4000, 1'b1, -1, -1, r, ok);
    e = exp_q.pop_front();
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL stall_done_seen got %0b exp 1", ok); end
    vectors++; if (r.timeout !== 1'b1 || r.iter !== 7'd8) begin miscompares++; $display("FAIL stall_timeout got %0b/%0d exp 1/8", r.timeout, r.iter); end
    vectors++; if (r.valid !== 1'b0 || r.out !== 32'd0) begin miscompares++; $display("FAIL stall_invalid got %0b/%0d exp 0/0", r.valid, r.out); end
    vectors++; if (r !== e) begin miscompares++; $display("FAIL stall_result got %h exp %h", r, e); end
  endtask

  task automatic test_single();
    res_t r, e;
    bit   ok;
    exp_q.push_back('{winner: 2'd2, valid: 1'b1, out: 32'd77, timeout: 1'b0, iter: 7'd0,
                      act: {32'd0, 32'd77, 32'd0, 32'd0}, act1: '0, lat: 16'd2});
    run_dut({32'd0, 32'd77, 32'd0, 32'd0}, 32'h4000, 1'b0, -1, -1, r, ok);
    e = exp_q.pop_front();
    vectors++; if (r.lat !== e.lat) begin miscompares++; $display("FAIL single_latency got %0d exp %0d", r.lat, e.lat); end
    vectors++; if (r.winner !== 2'd2 || r.out !== 32'd77 || r.valid !== 1'b1) begin miscompares++; $display("FAIL single_winner got %0d/%0d/%0b exp 2/77/1", r.winner, r.out, r.valid); end
    vectors++; if (r !== e) begin miscompares++; $display("FAIL single_result got %h exp %h", r, e); end
  endtask

  task automatic test_all_zero();
    res_t r, e;
    bit   ok;
    exp_q.push_back('{winner: 2'd0, valid: 1'b0, out: 32'd0, timeout: 1'b0, iter: 7'd0,
                      act: '0, act1: '0, lat: 16'd2});
    run_dut('0, 32'h4000, 1'b0, -1, -1, r, ok);
    e = exp_q.pop_front();
    vectors++; if (r !== e) begin miscompares++; $display("FAIL zero_result got %h exp %h", r, e); end
  endtask

  task automatic test_eps_zero();
    res_t r, e;
    bit   ok;
    logic [127:0] a;
    a = {32'd1, 32'd4, 32'd9, 32'd3};
    exp_q.push_back('{winner: 2'd0, valid: 1'b0, out: 32'd0, timeout: 1'b1, iter: 7'd8,
                      act: a, act1: a, lat: 16'd74});
    run_dut(a, 32'd0, 1'b1, -1, -1, r, ok);
    e = exp_q.pop_front();
    vectors++; if (r !== e) begin miscompares++; $display("FAIL eps0_result got %h exp %h", r, e); end
  endtask

  task automatic test_mid_reset();
    res_t r;
    bit   ok;
    run_dut({32'd40, 32'd30, 32'd20, 32'd10}, 32'h4000, 1'b0, -1, 6, r, ok);
    #1;
    vectors++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin miscompares++; $display("FAIL midrst_busy_done got %0b/%0b exp 0/0", busy1, done1); end
    vectors++; if ({winner1, valid1, out1, to1, iter1, act1_o} !== '0) begin miscompares++; $display("FAIL midrst_outputs got %h exp 0", {winner1, valid1, out1, to1, iter1, act1_o}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_example("after_rst", -1);
  endtask

  task automatic test_back_to_back();
    res_t r, e;
    bit   ok;
    logic [127:0] a;
    logic [31:0]  eps;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++)
        a[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 200));
      if (n == 0) a = {32'd50, 32'd90, 32'd50, 32'd0};
      eps = 32'($urandom_range(16'h1000, 16'hC000));
      exp_q.push_back(ref_model(a, eps, 64));
      run_dut(a, eps, 1'b0, -1, -1, r, ok);
      e = exp_q.pop_front();
      vectors++; if (r !== e) begin miscompares++; $display("FAIL b2b_%0d a=%h eps=%h got %h exp %h", n, a, eps, r, e); end
    end
  endtask

  initial begin
    test_reset();
    test_example("example", -1);
    test_single();
    test_all_zero();
    test_stall();
    test_eps_zero();
    test_example("busy_ignore", 2);
    test_mid_reset();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
